// File: rtl/cuppa_wvb_acq_pkg.sv
// Shared types and field widths for the CUPPA WVB acquisition controller.
// Widths match the unpacked configuration-bundle fields.
package cuppa_wvb_acq_pkg;

  localparam int PRE_W  = 6;
  localparam int POST_W = 15;
  localparam int CNST_W = 15;
  localparam int TEST_W = 15;

  // One down-counter is shared by PRE_FILL, CAPTURE and HOLDOFF, so it is as wide as the widest field.
  localparam int CNT_W = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_FILL = 3'd1,
    ARMED    = 3'd2,
    CAPTURE  = 3'd3,
    HOLDOFF  = 3'd4
  } acq_state_e;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/cuppa_wvb_test_trig_gen.sv
// Internal periodic test trigger: pulses every period+1 cycles while enabled.
// The count is held at zero while disabled so each enable starts from a known phase.
module cuppa_wvb_test_trig_gen
  import cuppa_wvb_acq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [TEST_W-1:0] period,
  output logic              test_pulse
);

  logic [TEST_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == period) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign test_pulse = en && (count == period);

endmodule

// File: rtl/cuppa_wvb_acq_ctrl.sv
// Acquisition controller for one CUPPA waveform buffer: pre-fill, trigger wait, capture, holdoff.
// Define CUPPA_WVB_TEST_TRIG_EN to build in the internal test-trigger generator.
module cuppa_wvb_acq_ctrl
  import cuppa_wvb_acq_pkg::*;
#(
  parameter int EVT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNST_W-1:0]    cnst_conf,
  input  logic [TEST_W-1:0]    test_conf,
  input  logic [POST_W-1:0]    post_conf,
  input  logic [PRE_W-1:0]     pre_conf,
  input  logic                 arm,
  input  logic                 trig_mode,
  input  logic                 cnst_run,
  input  logic                 discr_trig,
  input  logic                 wvb_overflow,
  output logic                 wvb_wr_en,
  output logic                 trig_flag,
  output logic                 eoe,
  output logic                 armed,
  output logic                 busy,
  output logic [EVT_CNT_W-1:0] evt_cnt
);

  acq_state_e       state;
  logic             arm_q;
  logic [CNT_W-1:0] cnt;
  logic             test_pulse;
  logic             trig;

`ifdef CUPPA_WVB_TEST_TRIG_EN
  cuppa_wvb_test_trig_gen u_test_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (trig_mode),
    .period     (test_conf),
    .test_pulse (test_pulse)
  );

  assign trig = trig_mode ? test_pulse : discr_trig;
`else
  logic unused_test_cfg;

  assign test_pulse      = 1'b0;
  assign trig            = discr_trig;
  assign unused_test_cfg = ^{trig_mode, test_conf, test_pulse};
`endif

  logic             arm_rise;
  logic             stop_req;
  logic             rearm_ok;
  logic             pre_zero;
  logic [CNT_W-1:0] pre_len;
  logic [CNT_W-1:0] post_len;
  logic [CNT_W-1:0] hold_len;
  acq_state_e       fill_state;

  assign arm_rise   = arm & ~arm_q;
  assign stop_req   = ~arm | wvb_overflow;
  assign rearm_ok   = cnst_run & arm & ~wvb_overflow;
  assign pre_zero   = (pre_conf == '0);
  assign pre_len    = {{(CNT_W-PRE_W){1'b0}}, pre_conf};
  assign post_len   = at_least_one(post_conf);
  assign hold_len   = at_least_one(cnst_conf);
  assign fill_state = pre_zero ? ARMED : PRE_FILL;

  // eoe and the event count are raised one cycle ahead so they land on the final capture sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      arm_q     <= 1'b0;
      cnt       <= '0;
      wvb_wr_en <= 1'b0;
      trig_flag <= 1'b0;
      eoe       <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      arm_q     <= arm;
      trig_flag <= 1'b0;
      eoe       <= 1'b0;

      case (state)
        IDLE: begin
          if (arm_rise && !wvb_overflow) begin
            state     <= fill_state;
            cnt       <= pre_len;
            wvb_wr_en <= 1'b1;
            armed     <= pre_zero;
            busy      <= 1'b1;
          end
        end

        PRE_FILL: begin
          if (stop_req) begin
            state     <= IDLE;
            wvb_wr_en <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt == CNT_W'(1)) begin
            state <= ARMED;
            armed <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ARMED: begin
          if (stop_req) begin
            state     <= IDLE;
            wvb_wr_en <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
          end else if (trig) begin
            state     <= CAPTURE;
            cnt       <= post_len;
            armed     <= 1'b0;
            trig_flag <= 1'b1;
            if (post_len == CNT_W'(1)) begin
              eoe     <= 1'b1;
              evt_cnt <= evt_cnt + 1'b1;
            end
          end
        end

        CAPTURE: begin
          if (cnt == CNT_W'(1)) begin
            state     <= HOLDOFF;
            cnt       <= hold_len;
            wvb_wr_en <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(2)) begin
              eoe     <= 1'b1;
              evt_cnt <= evt_cnt + 1'b1;
            end
          end
        end

        HOLDOFF: begin
          if (cnt != CNT_W'(1)) begin
            cnt <= cnt - 1'b1;
          end else if (rearm_ok) begin
            state     <= fill_state;
            cnt       <= pre_len;
            wvb_wr_en <= 1'b1;
            armed     <= pre_zero;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          wvb_wr_en <= 1'b0;
          armed     <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Event markers must always coincide with a written sample.
  a_eoe_writes: assert property (@(posedge clk) disable iff (!rst_n) eoe |-> wvb_wr_en);
  a_trig_writes: assert property (@(posedge clk) disable iff (!rst_n) trig_flag |-> wvb_wr_en);
  a_armed_busy: assert property (@(posedge clk) disable iff (!rst_n) armed |-> busy);

endmodule
